// File: rtl/display_pkg.sv
// Shared colour-path definitions: byte slot encoding, channel indices and the
// slot-to-channel select decode used by both the byte unpacker and the transmit mux.
package display_pkg;

   typedef enum logic [1:0] {
      SLOT0 = 2'd0,
      SLOT1 = 2'd1,
      SLOT2 = 2'd2
   } slot_e;

   // Bit positions of each channel inside a 3-bit one-hot select.
   localparam int CH_R = 0;
   localparam int CH_G = 1;
   localparam int CH_B = 2;

   // order=0: SLOT0=R, SLOT1=G, SLOT2=B; order=1: SLOT0=B, SLOT1=G, SLOT2=R.
   function automatic logic [2:0] slot_to_sel(input slot_e slot, input logic order);
      logic [2:0] sel;
      sel = 3'b000;
      case (slot)
         SLOT1:   sel[CH_G] = 1'b1;
         SLOT2:   sel[order ? CH_R : CH_B] = 1'b1;
         default: sel[order ? CH_B : CH_R] = 1'b1;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/rgb_byte_unpacker_if.sv
// Byte-in / pixel-out handshake bundle for the RGB byte unpacker.
// slave is the unpacker side; master is the byte source plus pixel sink.
interface rgb_byte_unpacker_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] in_data;
   logic             in_valid;
   logic             in_sof;
   logic             in_ready;
   logic [WIDTH-1:0] pix_r;
   logic [WIDTH-1:0] pix_g;
   logic [WIDTH-1:0] pix_b;
   logic             pix_sof;
   logic             pix_valid;
   logic             pix_ready;
   logic             sel_r;
   logic             sel_g;
   logic             sel_b;
   logic             align_err;
   logic [15:0]      pix_count;

   modport slave (
      input  in_data, in_valid, in_sof, pix_ready,
      output in_ready, pix_r, pix_g, pix_b, pix_sof, pix_valid,
             sel_r, sel_g, sel_b, align_err, pix_count
   );

   modport master (
      output in_data, in_valid, in_sof, pix_ready,
      input  in_ready, pix_r, pix_g, pix_b, pix_sof, pix_valid,
             sel_r, sel_g, sel_b, align_err, pix_count
   );
endinterface

// File: rtl/rgb_byte_unpacker.sv
// Reassembles three consecutive channel bytes into one parallel RGB pixel,
// with sof-driven realignment and a single registered output stage.
module rgb_byte_unpacker
   import display_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter bit CH_ORDER = 1'b0
) (
   input  logic                clk,
   input  logic                reset,
   rgb_byte_unpacker_if.slave  bus
);

   localparam logic [2:0] SEL_RST = slot_to_sel(SLOT0, CH_ORDER);

   slot_e            slot_q, slot_d;
   logic [2:0]       sel_q, sel_d;
   logic [WIDTH-1:0] stage0_q, stage0_d;
   logic [WIDTH-1:0] stage1_q, stage1_d;
   logic             stage_sof_q, stage_sof_d;
   logic [WIDTH-1:0] pix_r_q, pix_r_d;
   logic [WIDTH-1:0] pix_g_q, pix_g_d;
   logic [WIDTH-1:0] pix_b_q, pix_b_d;
   logic             pix_sof_q, pix_sof_d;
   logic             pix_valid_q, pix_valid_d;
   logic             align_err_q, align_err_d;
   logic [15:0]      pix_count_q, pix_count_d;

   logic in_ready;
   logic accept;
   logic realign;
   logic out_hs;

   // SLOT2 may only take a byte if the output register is free this cycle.
   assign in_ready = (slot_q != SLOT2) || !pix_valid_q || bus.pix_ready;
   assign accept   = bus.in_valid && in_ready;
   assign realign  = accept && bus.in_sof && (slot_q != SLOT0);
   assign out_hs   = pix_valid_q && bus.pix_ready;

   always_comb begin
      slot_d      = slot_q;
      stage0_d    = stage0_q;
      stage1_d    = stage1_q;
      stage_sof_d = stage_sof_q;
      pix_r_d     = pix_r_q;
      pix_g_d     = pix_g_q;
      pix_b_d     = pix_b_q;
      pix_sof_d   = pix_sof_q;
      pix_valid_d = pix_valid_q;
      pix_count_d = pix_count_q;
      align_err_d = realign;

      if (out_hs) begin
         pix_valid_d = 1'b0;
         pix_count_d = pix_count_q + 16'd1;
      end

      if (accept) begin
         if (slot_q == SLOT0 || realign) begin
            stage0_d    = bus.in_data;
            stage_sof_d = bus.in_sof;
            slot_d      = SLOT1;
         end else if (slot_q == SLOT1) begin
            stage1_d = bus.in_data;
            slot_d   = SLOT2;
         end else begin
            // Third byte: a reload here overrides the handshake clear above.
            pix_r_d     = CH_ORDER ? bus.in_data : stage0_q;
            pix_g_d     = stage1_q;
            pix_b_d     = CH_ORDER ? stage0_q : bus.in_data;
            pix_sof_d   = stage_sof_q;
            pix_valid_d = 1'b1;
            slot_d      = SLOT0;
         end
      end

      sel_d = slot_to_sel(slot_d, CH_ORDER);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         slot_q      <= SLOT0;
         sel_q       <= SEL_RST;
         stage0_q    <= '0;
         stage1_q    <= '0;
         stage_sof_q <= 1'b0;
         pix_r_q     <= '0;
         pix_g_q     <= '0;
         pix_b_q     <= '0;
         pix_sof_q   <= 1'b0;
         pix_valid_q <= 1'b0;
         align_err_q <= 1'b0;
         pix_count_q <= '0;
      end else begin
         slot_q      <= slot_d;
         sel_q       <= sel_d;
         stage0_q    <= stage0_d;
         stage1_q    <= stage1_d;
         stage_sof_q <= stage_sof_d;
         pix_r_q     <= pix_r_d;
         pix_g_q     <= pix_g_d;
         pix_b_q     <= pix_b_d;
         pix_sof_q   <= pix_sof_d;
         pix_valid_q <= pix_valid_d;
         align_err_q <= align_err_d;
         pix_count_q <= pix_count_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.pix_r     = pix_r_q;
   assign bus.pix_g     = pix_g_q;
   assign bus.pix_b     = pix_b_q;
   assign bus.pix_sof   = pix_sof_q;
   assign bus.pix_valid = pix_valid_q;
   assign bus.sel_r     = sel_q[CH_R];
   assign bus.sel_g     = sel_q[CH_G];
   assign bus.sel_b     = sel_q[CH_B];
   assign bus.align_err = align_err_q;
   assign bus.pix_count = pix_count_q;

endmodule

// File: tb/tb_rgb_byte_unpacker.sv
// Directed bench for rgb_byte_unpacker: two instances (CH_ORDER 0 and 1) share
// one byte stream; expected values are hand-computed per vector.
module tb_rgb_byte_unpacker;

   logic clk = 1'b0;
   logic reset;
   int   checks   = 0;
   int   failures = 0;
   int   stalls;
   logic [15:0] exp_cnt;

   always #5 clk = ~clk;

   rgb_byte_unpacker_if #(.WIDTH(8)) if0 ();
   rgb_byte_unpacker_if #(.WIDTH(8)) if1 ();

   rgb_byte_unpacker #(.WIDTH(8), .CH_ORDER(1'b0)) u0 (.clk(clk), .reset(reset), .bus(if0.slave));
   rgb_byte_unpacker #(.WIDTH(8), .CH_ORDER(1'b1)) u1 (.clk(clk), .reset(reset), .bus(if1.slave));

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [7:0] d, input logic sof);
      if0.in_valid = v; if0.in_data = d; if0.in_sof = sof;
      if1.in_valid = v; if1.in_data = d; if1.in_sof = sof;
   endtask

   task automatic set_ready(input logic r);
      if0.pix_ready = r;
      if1.pix_ready = r;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one byte and wait (bounded) until it is accepted.
   task automatic send(input logic [7:0] d, input logic sof);
      int n;
      n = 0;
      drive(1'b1, d, sof);
      #1;
      while (!if0.in_ready && n < 50) begin
         tick();
         n++;
      end
      if (n == 50) check_eq("send_timeout", 32'(n), 32'd0);
      tick();
      drive(1'b0, 8'h00, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1;
      drive(1'b0, 8'h00, 1'b0);
      set_ready(1'b1);
      #12;
      check_eq("rst_valid", if0.pix_valid, 1'b0);
      check_eq("rst_count", if0.pix_count, 16'd0);
      check_eq("rst_sel0", {if0.sel_r, if0.sel_g, if0.sel_b}, 3'b100);
      check_eq("rst_sel1", {if1.sel_r, if1.sel_g, if1.sel_b}, 3'b001);
      check_eq("rst_ready", if0.in_ready, 1'b1);
      check_eq("rst_aerr", if0.align_err, 1'b0);
      reset = 1'b0;
      tick();

      // sof on a SLOT0 byte is normal; sel walks r,g,b,r
      send(8'h11, 1'b1);
      check_eq("t1_aerr", if0.align_err, 1'b0);
      check_eq("t1_sel_g", {if0.sel_r, if0.sel_g, if0.sel_b}, 3'b010);
      send(8'h22, 1'b0);
      check_eq("t1_sel_b", {if0.sel_r, if0.sel_g, if0.sel_b}, 3'b001);
      send(8'h33, 1'b0);
      check_eq("t1_sel_r", {if0.sel_r, if0.sel_g, if0.sel_b}, 3'b100);
      check_eq("t1_valid", if0.pix_valid, 1'b1);
      check_eq("t1_rgb", {if0.pix_r, if0.pix_g, if0.pix_b}, 24'h112233);
      check_eq("t1_sof", if0.pix_sof, 1'b1);
      tick();
      check_eq("t1_valid_clr", if0.pix_valid, 1'b0);
      check_eq("t1_count", if0.pix_count, 16'd1);

      send(8'hAA, 1'b0);
      send(8'hBB, 1'b0);
      send(8'hCC, 1'b0);
      check_eq("t2_rgb0", {if0.pix_r, if0.pix_g, if0.pix_b}, 24'hAABBCC);
      check_eq("t2_rgb1", {if1.pix_r, if1.pix_g, if1.pix_b}, 24'hCCBBAA);
      check_eq("t2_sof", if0.pix_sof, 1'b0);
      tick();
      exp_cnt = 16'd2;
      check_eq("t2_count", if0.pix_count, exp_cnt);

      // Backpressure
      set_ready(1'b0);
      send(8'h01, 1'b0);
      send(8'h02, 1'b0);
      send(8'h03, 1'b0);
      check_eq("t3_valid", if0.pix_valid, 1'b1);
      send(8'h04, 1'b0);
      send(8'h05, 1'b0);
      drive(1'b1, 8'h06, 1'b0);
      #1;
      check_eq("t3_ready_lo", if0.in_ready, 1'b0);
      tick();
      tick();
      check_eq("t3_hold", {if0.pix_r, if0.pix_g, if0.pix_b}, 24'h010203);
      check_eq("t3_hold_v", if0.pix_valid, 1'b1);
      check_eq("t3_hold_cnt", if0.pix_count, exp_cnt);
      set_ready(1'b1);
      #1;
      check_eq("t3_ready_hi", if0.in_ready, 1'b1);
      tick();
      drive(1'b0, 8'h00, 1'b0);
      check_eq("t3_second", {if0.pix_r, if0.pix_g, if0.pix_b}, 24'h040506);
      check_eq("t3_second_v", if0.pix_valid, 1'b1);
      check_eq("t3_cnt_mid", if0.pix_count, exp_cnt + 16'd1);
      tick();
      exp_cnt = exp_cnt + 16'd2;
      check_eq("t3_count", if0.pix_count, exp_cnt);
      check_eq("t3_valid_clr", if0.pix_valid, 1'b0);

      // Streaming 300 bytes back-to-back
      stalls = 0;
      for (int i = 0; i < 300; i++) begin
         drive(1'b1, 8'(i), 1'b0);
         #1;
         if (!if0.in_ready) stalls++;
         tick();
      end
      drive(1'b0, 8'h00, 1'b0);
      check_eq("t4_last", {if0.pix_r, if0.pix_g, if0.pix_b}, {8'(297), 8'(298), 8'(299)});
      tick();
      exp_cnt = exp_cnt + 16'd100;
      check_eq("t4_stalls", 32'(stalls), 32'd0);
      check_eq("t4_count", if0.pix_count, exp_cnt);

      // Wrap: preload counter just below the top
      force u0.pix_count_q = 16'hFFFE;
      tick();
      release u0.pix_count_q;
      send(8'h0A, 1'b0);
      send(8'h0B, 1'b0);
      send(8'h0C, 1'b0);
      tick();
      check_eq("t5_ffff", if0.pix_count, 16'hFFFF);
      send(8'h0D, 1'b0);
      send(8'h0E, 1'b0);
      send(8'h0F, 1'b0);
      tick();
      check_eq("t5_wrap", if0.pix_count, 16'h0000);

      // Realignment: sof in SLOT1 discards byte 01
      send(8'h01, 1'b0);
      send(8'hA5, 1'b1);
      check_eq("t6_aerr", if0.align_err, 1'b1);
      check_eq("t6_sel_g", {if0.sel_r, if0.sel_g, if0.sel_b}, 3'b010);
      send(8'h02, 1'b0);
      check_eq("t6_aerr_pulse", if0.align_err, 1'b0);
      send(8'h03, 1'b0);
      check_eq("t6_rgb", {if0.pix_r, if0.pix_g, if0.pix_b}, 24'hA50203);
      check_eq("t6_sof", if0.pix_sof, 1'b1);
      tick();
      check_eq("t6_count", if0.pix_count, 16'd1);

      // Reset mid-pixel with a pending output pixel
      set_ready(1'b0);
      send(8'h31, 1'b0);
      send(8'h32, 1'b0);
      send(8'h33, 1'b0);
      send(8'h34, 1'b0);
      send(8'h35, 1'b0);
      check_eq("t7_pend", if0.pix_valid, 1'b1);
      reset = 1'b1;
      #1;
      check_eq("t7_valid", if0.pix_valid, 1'b0);
      check_eq("t7_count", if0.pix_count, 16'd0);
      check_eq("t7_sel0", {if0.sel_r, if0.sel_g, if0.sel_b}, 3'b100);
      check_eq("t7_sel1", {if1.sel_r, if1.sel_g, if1.sel_b}, 3'b001);
      #2;
      reset = 1'b0;
      set_ready(1'b1);
      tick();
      send(8'h07, 1'b0);
      send(8'h08, 1'b0);
      send(8'h09, 1'b0);
      check_eq("t7_rgb", {if0.pix_r, if0.pix_g, if0.pix_b}, 24'h070809);
      tick();
      check_eq("t7_count_after", if0.pix_count, 16'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rgb_byte_unpacker.md
Name: rgb_byte_unpacker

Overview:
- Receive side of the byte-serial colour path: takes a stream of 8-bit channel bytes and reassembles them into parallel R/G/B pixels.
- Each pixel arrives as three consecutive bytes, in R, G, B order (or B, G, R when CH_ORDER=1).
- Sits between the byte link and the pixel pipeline; valid/ready on both sides.
- Exposes one-hot slot selects that mirror the channel-select encoding used on the transmit multiplexer.

Parameters:
- WIDTH, 8, channel width in bits.
- CH_ORDER, 0, 0 = bytes arrive R,G,B; 1 = bytes arrive B,G,R.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_data  input  WIDTH  channel byte.
- in_valid  input  1  in_data/in_sof valid.
- in_sof  input  1  start-of-frame marker qualifying the current byte.
- in_ready  output  1  byte accepted when in_valid && in_ready.
- pix_r  output  WIDTH  red channel of the assembled pixel.
- pix_g  output  WIDTH  green channel of the assembled pixel.
- pix_b  output  WIDTH  blue channel of the assembled pixel.
- pix_sof  output  1  pixel is the first pixel of a frame.
- pix_valid  output  1  pix_* valid.
- pix_ready  input  1  downstream accepts the pixel when pix_valid && pix_ready.
- sel_r  output  1  one-hot: the next byte expected is red.
- sel_g  output  1  one-hot: the next byte expected is green.
- sel_b  output  1  one-hot: the next byte expected is blue.
- align_err  output  1  one-cycle pulse: an in_sof byte arrived in a non-first slot.
- pix_count  output  16  count of pixels handed off since reset.

Behaviour:
- Slot state machine: SLOT0 → SLOT1 → SLOT2 → SLOT0.
  - Advances one state per accepted byte.
  - Slot-to-channel map: CH_ORDER=0 gives SLOT0=R, SLOT1=G, SLOT2=B. CH_ORDER=1 gives SLOT0=B, SLOT1=G, SLOT2=R.
- sel_r/sel_g/sel_b are a registered decode of the current slot through that map. Exactly one is high at all times, including during reset.
- SLOT0 and SLOT1 bytes are written into staging registers; in_sof of the SLOT0 byte is staged too.
- On SLOT2 acceptance:
  - Staged bytes plus the current byte load pix_r/g/b; the staged sof loads pix_sof.
  - pix_valid=1 on the next edge. Latency is 1 cycle from third-byte acceptance to pix_valid.
- in_ready:
  - In SLOT0 and SLOT1: 1.
  - In SLOT2: !pix_valid || pix_ready (combinational from pix_ready).
- Output hold: pix_* and pix_valid stay stable while pix_valid && !pix_ready.
- Output handshake: pix_valid && pix_ready clears pix_valid and increments pix_count. pix_count wraps 16'hFFFF → 0.
- Simultaneous handshake and SLOT2 acceptance: the output register reloads and pix_valid stays 1; pix_count increments. Sustained throughput is 1 byte/cycle with no bubbles.
- Realignment: an accepted byte with in_sof=1 while the slot is not SLOT0 triggers all of:
  - align_err pulses 1 cycle.
  - The partial pixel is discarded (pix_count unaffected).
  - The byte is taken as SLOT0 with sof=1.
  - The slot goes to SLOT1.
- in_sof=1 in SLOT0 is normal: no error.
- in_sof on bytes that are not accepted is ignored.
- Reset values (asynchronous, any time, including mid-pixel):
  - slot=SLOT0; staging cleared.
  - pix_r/g/b=0, pix_sof=0, pix_valid=0, align_err=0, pix_count=0.
  - sel_* = decode of SLOT0 (sel_r=1 for CH_ORDER=0, sel_b=1 for CH_ORDER=1).
  - Any pending output pixel is lost.
- in_valid=0 holds all state; no timeouts.

Decomposition:
- Shared package display_pkg holds:
  - slot enum SLOT0/SLOT1/SLOT2 (2-bit);
  - localparams CH_R/CH_G/CH_B;
  - function slot_to_sel(slot, order) returning the 3-bit one-hot select.
- The transmit multiplexer's select generation reuses slot_to_sel.
- No sub-module; the output register stage is small enough to stay inline.

Test Plan:
- Reset then bytes 8'h11, 8'h22, 8'h33 with in_valid=1 and pix_ready=1 (CH_ORDER=0) → one cycle after the third byte: pix_r=11, pix_g=22, pix_b=33, pix_valid=1, pix_count=1. sel sequence r, g, b, r.
- CH_ORDER=1, bytes AA, BB, CC → pix_b=AA, pix_g=BB, pix_r=CC. sel_b=1 after reset.
- Backpressure: pix_ready=0 with 6 bytes offered → first pixel held stable; in_ready=0 in SLOT2 of the second pixel. After pix_ready=1, both pixels delivered in order and pix_count=2.
- Streaming 300 bytes back-to-back with pix_ready=1 → 100 pixels, no in_ready deassertion, pix_count=100. Separately, preload pix_count to near 16'hFFFF (65535 pixels) → observe wrap to 0.
- in_sof=1 on a byte in SLOT1 (after byte 01) → align_err one pulse; next bytes 02, 03 complete a pixel (sof-byte, 02, 03) with pix_sof=1; byte 01 is never output.
- reset asserted mid-pixel (after 2 bytes, with pix_valid=1 held) → immediately pix_valid=0, pix_count=0, sel_r=1; the next 3 bytes form a fresh pixel.
